// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter: ALU command codes, FSM states,
// datapath widths and a saturating counter helper.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 3;
  localparam int FLAG_W = 3;
  localparam int STAT_W = 16;

  // Command codes understood by the external structural ALU
  typedef enum logic [CMD_W-1:0] {
    ADD_ALU  = 3'd0,
    SUB_ALU  = 3'd1,
    XOR_ALU  = 3'd2,
    SLT_ALU  = 3'd3,
    AND_ALU  = 3'd4,
    NAND_ALU = 3'd5,
    NOR_ALU  = 3'd6,
    OR_ALU   = 3'd7
  } alu_cmd_t;

  // Arbiter FSM: grant, let the ALU settle, hand the response out
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Statistics counters stick at all-ones instead of wrapping
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker. Returns the first
// asserted request at or above 'pointer', wrapping around NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  // Walk the requesters starting at the pointer; the first hit wins
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(pointer) + i >= NUM_REQ) idx = ID_W'(int'(pointer) + i - NUM_REQ);
      else                              idx = ID_W'(int'(pointer) + i);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 32-bit ALU between NUM_REQ requesters.
// Round-robin grant in IDLE, operands held for SETTLE_CYCLES in EXEC while
// the ripple ALU settles, then result/flags are captured and offered on a
// valid/ready response port in RESP.
// Optional build macro ALU_ARB_STATS_EN adds saturating per-requester op
// counters (stat_ops) and an overflow counter (stat_ovf).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int ID_W          = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  input  logic [CMD_W*NUM_REQ-1:0]  req_cmd,
  output logic [DATA_W-1:0]         alu_operandA,
  output logic [DATA_W-1:0]         alu_operandB,
  output logic [CMD_W-1:0]          alu_command,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_carryout,
  input  logic                      alu_zero,
  input  logic                      alu_overflow,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [FLAG_W-1:0]         rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_W*NUM_REQ-1:0] stat_ops,
  output logic [STAT_W-1:0]         stat_ovf
`endif
);

  // Settle counter only needs to hold SETTLE_CYCLES-1
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_t          state_reg;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [ID_W-1:0]     id_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [DATA_W-1:0]   op_a_reg;
  logic [DATA_W-1:0]   op_b_reg;
  logic [CMD_W-1:0]    cmd_reg;
  logic                rsp_valid_reg;
  logic [ID_W-1:0]     rsp_id_reg;
  logic [DATA_W-1:0]   rsp_result_reg;
  logic [FLAG_W-1:0]   rsp_flags_reg;

  logic [DATA_W-1:0]   a_arr   [NUM_REQ];
  logic [DATA_W-1:0]   b_arr   [NUM_REQ];
  logic [CMD_W-1:0]    cmd_arr [NUM_REQ];

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                grant_any;

  genvar gi;

  // Unpack the flat request buses into per-requester views
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign a_arr[gi]   = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi]   = req_b[gi*DATA_W +: DATA_W];
    assign cmd_arr[gi] = req_cmd[gi*CMD_W +: CMD_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req      (req_valid),
    .pointer  (rr_ptr_reg),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  // Grants are offered only while idle; outside IDLE requests are ignored
  assign req_ready = (state_reg == IDLE) ? grant : '0;

  // Main FSM: grant -> settle -> respond, with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      id_reg         <= '0;
      count_reg      <= '0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      cmd_reg        <= ADD_ALU;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            op_a_reg   <= a_arr[grant_id];
            op_b_reg   <= b_arr[grant_id];
            cmd_reg    <= cmd_arr[grant_id];
            id_reg     <= grant_id;
            count_reg  <= CNT_W'(SETTLE_CYCLES - 1);
            rr_ptr_reg <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state_reg  <= EXEC;
          end
        end
        EXEC: begin
          if (count_reg == '0) begin
            rsp_result_reg <= alu_result;
            rsp_flags_reg  <= {alu_carryout, alu_zero, alu_overflow};
            rsp_id_reg     <= id_reg;
            rsp_valid_reg  <= 1'b1;
            state_reg      <= RESP;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign alu_operandA = op_a_reg;
  assign alu_operandB = op_b_reg;
  assign alu_command  = cmd_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_id       = rsp_id_reg;
  assign rsp_result   = rsp_result_reg;
  assign rsp_flags    = rsp_flags_reg;

`ifdef ALU_ARB_STATS_EN
  logic               rsp_done;
  logic [STAT_W-1:0]  ovf_cnt_reg;

  assign rsp_done = (state_reg == RESP) && rsp_valid_reg && rsp_ready;

  // One completed-op counter per requester, bumped on its response handshake
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [STAT_W-1:0] ops_cnt_reg;
    // Count handshakes tagged with this requester id
    always_ff @(posedge clk) begin
      if (!reset_n)                                    ops_cnt_reg <= '0;
      else if (rsp_done && rsp_id_reg == ID_W'(gi))    ops_cnt_reg <= sat_inc(ops_cnt_reg);
    end
    assign stat_ops[gi*STAT_W +: STAT_W] = ops_cnt_reg;
  end

  // Count handshakes whose captured overflow flag was set
  always_ff @(posedge clk) begin
    if (!reset_n)                           ovf_cnt_reg <= '0;
    else if (rsp_done && rsp_flags_reg[0])  ovf_cnt_reg <= sat_inc(ovf_cnt_reg);
  end
  assign stat_ovf = ovf_cnt_reg;
`endif

endmodule
